// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling over six independent channels.
// Even rows park the pair maxima in a half-width row buffer; odd rows finish each window.
module relu_maxpool2x2 #(
    parameter int BITWIDTH  = 8,
    parameter int IN_WIDTH  = 28,
    parameter int IN_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [BITWIDTH*2-1:0] din1,
    input  logic signed [BITWIDTH*2-1:0] din2,
    input  logic signed [BITWIDTH*2-1:0] din3,
    input  logic signed [BITWIDTH*2-1:0] din4,
    input  logic signed [BITWIDTH*2-1:0] din5,
    input  logic signed [BITWIDTH*2-1:0] din6,
    output logic                         out_valid,
    output logic signed [BITWIDTH*2-1:0] dout1,
    output logic signed [BITWIDTH*2-1:0] dout2,
    output logic signed [BITWIDTH*2-1:0] dout3,
    output logic signed [BITWIDTH*2-1:0] dout4,
    output logic signed [BITWIDTH*2-1:0] dout5,
    output logic signed [BITWIDTH*2-1:0] dout6,
    output logic                         out_last
);

    localparam int DW     = BITWIDTH * 2;
    localparam int NCH    = 6;
    localparam int HALF_W = IN_WIDTH / 2;
    localparam int CW     = $clog2(IN_WIDTH);
    localparam int IW     = CW - 1;
    localparam int RW     = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;

    logic signed [DW-1:0] din_a  [NCH];
    logic signed [DW-1:0] relu_a [NCH];

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [DW-1:0] h_q    [NCH];
    logic signed [DW-1:0] h_d    [NCH];
    logic signed [DW-1:0] rb_q   [NCH][HALF_W];
    logic signed [DW-1:0] rb_d   [NCH][HALF_W];
    logic signed [DW-1:0] dout_q [NCH];
    logic signed [DW-1:0] dout_d [NCH];
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    logic                 col_last, row_last;
    logic [IW-1:0]        rb_idx;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign din_a[0] = din1;
    assign din_a[1] = din2;
    assign din_a[2] = din3;
    assign din_a[3] = din4;
    assign din_a[4] = din5;
    assign din_a[5] = din6;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            relu_a[k] = din_a[k][DW-1] ? '0 : din_a[k];
        end
    end

    assign col_last = (col_q == CW'(IN_WIDTH - 1));
    assign row_last = (row_q == RW'(IN_HEIGHT - 1));
    assign rb_idx   = col_q[CW-1:1];

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        h_d         = h_q;
        rb_d        = rb_q;
        dout_d      = dout_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int k = 0; k < NCH; k++) begin
                if (!col_q[0]) begin
                    h_d[k] = relu_a[k];
                end else if (!row_q[0]) begin
                    rb_d[k][rb_idx] = smax(h_q[k], relu_a[k]);
                end else begin
                    dout_d[k] = smax(rb_q[k][rb_idx], smax(h_q[k], relu_a[k]));
                end
            end
            out_valid_d = col_q[0] & row_q[0];
            out_last_d  = col_last & row_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                h_q[k]    <= '0;
                dout_q[k] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            h_q         <= h_d;
            dout_q      <= dout_d;
        end
    end

    // Row buffer needs no reset: every entry is written on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        rb_q <= rb_d;
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign dout1     = dout_q[0];
    assign dout2     = dout_q[1];
    assign dout3     = dout_q[2];
    assign dout4     = dout_q[3];
    assign dout5     = dout_q[4];
    assign dout6     = dout_q[5];

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Scoreboard bench: a whole-frame reference model queues expected pooled pixels,
// and a negedge monitor compares them against every DUT output cycle.
module tb_relu_maxpool2x2;

    localparam int DW     = 16;
    localparam int W      = 28;
    localparam int H      = 28;
    localparam int NCH    = 6;
    localparam int POOLED = W * H / 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] din1 = '0, din2 = '0, din3 = '0, din4 = '0, din5 = '0, din6 = '0;
    logic                 out_valid;
    logic                 out_last;
    logic signed [DW-1:0] dout1, dout2, dout3, dout4, dout5, dout6;
    logic signed [DW-1:0] dout_a [NCH];

    relu_maxpool2x2 #(.BITWIDTH(8), .IN_WIDTH(W), .IN_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .din1(din1), .din2(din2), .din3(din3), .din4(din4), .din5(din5), .din6(din6),
        .out_valid(out_valid),
        .dout1(dout1), .dout2(dout2), .dout3(dout3), .dout4(dout4), .dout5(dout5), .dout6(dout6),
        .out_last(out_last)
    );

    assign dout_a[0] = dout1;
    assign dout_a[1] = dout2;
    assign dout_a[2] = dout3;
    assign dout_a[3] = dout4;
    assign dout_a[4] = dout5;
    assign dout_a[5] = dout6;

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt++;

    typedef struct packed {
        logic [NCH*DW-1:0] vals;
        logic              last;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   pulse_cnt     = 0;
    int   last_cnt      = 0;
    int   first_val     = -1;
    int   final_val     = -1;

    int   drv [NCH];
    int   pix [NCH][H][W];
    int   mr = 0;
    int   mc = 0;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Reference model: store the rectified frame; when a window completes, pool it directly.
    task automatic modelBeat(input int cyc);
        exp_t e;
        int   m;
        for (int k = 0; k < NCH; k++) pix[k][mr][mc] = relu(drv[k]);
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            e.vals = '0;
            for (int k = 0; k < NCH; k++) begin
                m = max4(pix[k][mr-1][mc-1], pix[k][mr-1][mc], pix[k][mr][mc-1], pix[k][mr][mc]);
                e.vals[k*DW +: DW] = m[DW-1:0];
            end
            e.last = (mr == H - 1) && (mc == W - 1);
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic applyStimulus(input bit v);
        logic signed [DW-1:0] t [NCH];
        @(negedge clk);
        in_valid = v;
        for (int k = 0; k < NCH; k++) begin
            if (v) t[k] = drv[k][DW-1:0];
            else   t[k] = DW'($urandom);
        end
        din1 = t[0]; din2 = t[1]; din3 = t[2]; din4 = t[3]; din5 = t[4]; din6 = t[5];
        if (v) modelBeat(cycle_cnt + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    // mode 0 ramp, 1 constant, 2 single spike at (0,1), 3 random data
    task automatic sendFrame(input int mode, input int val, input int gap_pct, input int nbeats);
        logic signed [DW-1:0] r16;
        int r, c;
        for (int p = 0; p < nbeats; p++) begin
            r = p / W;
            c = p % W;
            while (int'($urandom_range(99)) < gap_pct) applyStimulus(1'b0);
            for (int k = 0; k < NCH; k++) begin
                case (mode)
                    0:       drv[k] = r * W + c;
                    1:       drv[k] = val;
                    2:       drv[k] = (r == 0 && c == 1) ? (k + 1) * 100 : -5;
                    default: begin r16 = DW'($urandom); drv[k] = int'(r16); end
                endcase
            end
            applyStimulus(1'b1);
        end
    endtask

    task automatic checkPhase(input string name, input int p0, input int l0,
                              input int exp_pulses, input int exp_lasts);
        checkOutput({name, "_pulses"}, pulse_cnt - p0, exp_pulses);
        checkOutput({name, "_lasts"}, last_cnt - l0, exp_lasts);
        checkOutput({name, "_pending"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cycle_cnt) begin
                e = exp_q.pop_front();
                checkOutput("out_valid", int'(out_valid), 1);
                if (out_valid) begin
                    for (int k = 0; k < NCH; k++)
                        checkOutput($sformatf("dout%0d", k + 1), int'(dout_a[k]),
                                    int'($signed(e.vals[k*DW +: DW])));
                    checkOutput("out_last", int'(out_last), int'(e.last));
                end
            end else begin
                checkOutput("out_valid_idle", int'(out_valid), 0);
            end
            if (out_valid) begin
                pulse_cnt++;
                if (out_last) last_cnt++;
                if (first_val < 0) first_val = int'(dout1);
                final_val = int'(dout1);
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0, l0;
        for (int k = 0; k < NCH; k++) drv[k] = 0;

        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_dout1", int'(dout1), 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_out_last", int'(out_last), 0);
            for (int k = 0; k < NCH; k++)
                checkOutput($sformatf("idle_dout%0d", k + 1), int'(dout_a[k]), 0);
        end

        $display("[TB] ramp frame");
        p0 = pulse_cnt; l0 = last_cnt; first_val = -1;
        sendFrame(0, 0, 0, W * H);
        idle(4);
        checkPhase("ramp", p0, l0, POOLED, 1);
        checkOutput("ramp_first_dout1", first_val, 29);
        checkOutput("ramp_final_dout1", final_val, 783);

        $display("[TB] negative frames");
        p0 = pulse_cnt; l0 = last_cnt;
        sendFrame(1, -16, 0, W * H);
        sendFrame(1, -32768, 0, W * H);
        idle(4);
        checkPhase("negative", p0, l0, 2 * POOLED, 2);

        $display("[TB] spike frame");
        p0 = pulse_cnt; l0 = last_cnt; first_val = -1;
        sendFrame(2, 0, 0, W * H);
        idle(4);
        checkPhase("spike", p0, l0, POOLED, 1);
        checkOutput("spike_first_dout1", first_val, 100);

        $display("[TB] gapped ramp frame");
        p0 = pulse_cnt; l0 = last_cnt;
        sendFrame(0, 0, 50, W * H);
        idle(4);
        checkPhase("gapped", p0, l0, POOLED, 1);

        $display("[TB] random data frames");
        p0 = pulse_cnt; l0 = last_cnt;
        sendFrame(3, 0, 0, W * H);
        sendFrame(3, 0, 30, W * H);
        idle(4);
        checkPhase("random", p0, l0, 2 * POOLED, 2);

        $display("[TB] mid-frame reset");
        p0 = pulse_cnt; l0 = last_cnt;
        sendFrame(0, 0, 0, 100);
        idle(3);
        checkPhase("prereset", p0, l0, 22, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mr = 0;
        mc = 0;
        #1;
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_dout1", int'(dout1), 0);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        p0 = pulse_cnt; l0 = last_cnt;
        sendFrame(0, 0, 0, W * H);
        sendFrame(0, 0, 0, W * H);
        idle(5);
        checkPhase("postreset", p0, l0, 2 * POOLED, 2);
        checkOutput("postreset_final_dout1", final_val, 783);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
